sfp_frame_link: RTL and testbench



---
 rtl/sfp_link_pkg.sv | 51 +++++
 rtl/sfp_frame_rx.sv | 167 ++++++++++++++++
 rtl/sfp_frame_link.sv | 151 +++++++++++++++
 tb/tb_sfp_frame_link.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfp_link_pkg
// Description : Shared constants and state encodings for the SFP frame link.
//               A frame is 12 data words of 32 bits, 384 bits in total. On the
//               wire it is delimited by K-character SOF and EOF words and
//               carries a 32-bit additive checksum. Between frames the link
//               carries IDLE comma words.
// Revision    : 1.0 - initial release
// ============================================================================
package sfp_link_pkg;

  localparam int unsigned c_WORD_W    = 32;
  localparam int unsigned c_NUM_WORDS = 12;
  localparam int unsigned c_FRAME_W   = c_WORD_W * c_NUM_WORDS;

  // Index of the last data word, sized to match the word counters.
  localparam logic [3:0]  c_LAST_IDX  = 4'd11;

  // Control words carry their K character in byte [7:0].
  localparam logic [31:0] c_IDLE_WORD = 32'h0000_00BC;  // K28.5
  localparam logic [31:0] c_SOF_WORD  = 32'h0000_00FB;  // K27.7
  localparam logic [31:0] c_EOF_WORD  = 32'h0000_00FD;  // K29.7
  localparam logic [3:0]  c_K_CTRL    = 4'b0001;
  localparam logic [3:0]  c_K_DATA    = 4'b0000;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_SOF  = 3'd1,
    TX_DATA = 3'd2,
    TX_CSUM = 3'd3,
    TX_EOF  = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_HUNT = 3'd0,
    RX_DATA = 3'd1,
    RX_CSUM = 3'd2,
    RX_EOF  = 3'd3
  } rx_state_t;

  // A control word only matches when both the byte pattern and the K flags
  // agree exactly.
  function automatic logic is_ctrl_word(input logic [31:0] w,
                                        input logic [3:0]  k,
                                        input logic [31:0] exp_w);
    return (w == exp_w) && (k == c_K_CTRL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : sfp_frame_rx
// Description : Receive deframer. Hunts for SOF, assembles 12 data words,
//               checks the running checksum and the EOF slot, then either
//               publishes the frame (end pulse) or rejects it (error pulse,
//               saturating error count).
// Ports       : i_clk, i_rst        clock, synchronous active-high reset
//               i_rxdata/charisk    byte-aligned transceiver word and K flags
//               i_rx_ready          link aligned; low forces hunting
//               o_rx_data           last accepted frame
//               o_rx_end_flag       pulse when o_rx_data updates
//               o_rx_err_flag       pulse when a frame is rejected
//               o_rx_err_cnt        rejected-frame count, saturating
//               o_rx_state          current RX state
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_frame_rx
  import sfp_link_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_rxdata,
  input  logic [3:0]           i_rxcharisk,
  input  logic                 i_rx_ready,
  output logic [c_FRAME_W-1:0] o_rx_data,
  output logic                 o_rx_end_flag,
  output logic                 o_rx_err_flag,
  output logic [15:0]          o_rx_err_cnt,
  output logic [2:0]           o_rx_state
);

  rx_state_t              r_state;
  rx_state_t              w_next;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_next;
  logic [c_FRAME_W-1:0]   r_buf;
  logic [31:0]            r_acc;
  logic                   r_bad;
  logic                   w_bad_next;
  logic [c_FRAME_W-1:0]   r_data;
  logic                   r_end;
  logic                   r_err;
  logic [15:0]            r_err_cnt;

  logic w_is_sof;
  logic w_is_eof;
  logic w_is_k;
  logic w_end;
  logic w_err;
  logic w_clr;
  logic w_take;

  assign w_is_sof = is_ctrl_word(i_rxdata, i_rxcharisk, c_SOF_WORD);
  assign w_is_eof = is_ctrl_word(i_rxdata, i_rxcharisk, c_EOF_WORD);
  assign w_is_k   = |i_rxcharisk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RX_HUNT;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_bad_next = r_bad;
    w_end      = 1'b0;
    w_err      = 1'b0;
    w_clr      = 1'b0;
    w_take     = 1'b0;

    if (!i_rx_ready) begin
      // Loss of alignment silently discards whatever was being assembled.
      w_next = RX_HUNT;
    end else begin
      case (r_state)
        RX_HUNT: begin
          if (w_is_sof) begin
            w_next     = RX_DATA;
            w_cnt_next = 4'd0;
            w_clr      = 1'b1;
            w_bad_next = 1'b0;
          end
        end

        RX_DATA, RX_CSUM: begin
          if (w_is_k) begin
            // Any K character inside the payload aborts the frame. A stray
            // SOF is taken as the start of a new frame so no words are lost.
            w_err = 1'b1;
            if (w_is_sof) begin
              w_next     = RX_DATA;
              w_cnt_next = 4'd0;
              w_clr      = 1'b1;
              w_bad_next = 1'b0;
            end else begin
              w_next = RX_HUNT;
            end
          end else if (r_state == RX_DATA) begin
            w_take = 1'b1;
            if (r_cnt == c_LAST_IDX) begin
              w_next = RX_CSUM;
            end else begin
              w_cnt_next = r_cnt + 4'd1;
            end
          end else begin
            // Mismatch is remembered; the frame is still walked to its EOF slot.
            w_bad_next = (i_rxdata != r_acc);
            w_next     = RX_EOF;
          end
        end

        RX_EOF: begin
          w_next = RX_HUNT;
          if (w_is_eof && !r_bad) begin
            w_end = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end

        default: w_next = RX_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf     <= '0;
      r_acc     <= 32'd0;
      r_bad     <= 1'b0;
      r_data    <= '0;
      r_end     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 16'd0;
    end else begin
      r_bad <= w_bad_next;
      r_end <= w_end;
      r_err <= w_err;
      if (w_clr) begin
        r_acc <= 32'd0;
      end else if (w_take) begin
        r_acc <= r_acc + i_rxdata;
        r_buf <= {r_buf[c_FRAME_W-33:0], i_rxdata};
      end
      if (w_end) begin
        r_data <= r_buf;
      end
      if (w_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign o_rx_data     = r_data;
  assign o_rx_end_flag = r_end;
  assign o_rx_err_flag = r_err;
  assign o_rx_err_cnt  = r_err_cnt;
  assign o_rx_state    = r_state;

endmodule
`default_nettype wire

// File: rtl/sfp_frame_link.sv
`default_nettype none
// ============================================================================
// Module      : sfp_frame_link
// Description : Link-layer framer/deframer between a 384-bit frame interface
//               and a 32-bit 8b/10b transceiver user port. The TX serializer
//               lives here; the RX deframer is sfp_frame_rx.
// Ports       : i_clk, i_rst          clock, synchronous active-high reset
//               i_tx_data             frame to send, latched on accepted start
//               i_tx_start_flag       one-cycle start request
//               o_tx_end_flag         pulse coincident with the EOF word
//               o_tx_busy             high from accepted start through EOF
//               o_gt_txdata/charisk   transceiver TX word and K flags
//               i_gt_rxdata/charisk   transceiver RX word and K flags
//               i_gt_rx_ready         RX link aligned
//               o_rx_data             last good received frame
//               o_rx_end_flag         pulse when o_rx_data updates
//               o_rx_err_flag         pulse when a frame is rejected
//               o_rx_err_cnt          saturating rejected-frame count
//               o_tx_state/rx_state   FSM states
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_frame_link
  import sfp_link_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [c_FRAME_W-1:0] i_tx_data,
  input  logic                 i_tx_start_flag,
  output logic                 o_tx_end_flag,
  output logic                 o_tx_busy,
  output logic [31:0]          o_gt_txdata,
  output logic [3:0]           o_gt_txcharisk,
  input  logic [31:0]          i_gt_rxdata,
  input  logic [3:0]           i_gt_rxcharisk,
  input  logic                 i_gt_rx_ready,
  output logic [c_FRAME_W-1:0] o_rx_data,
  output logic                 o_rx_end_flag,
  output logic                 o_rx_err_flag,
  output logic [15:0]          o_rx_err_cnt,
  output logic [2:0]           o_tx_state,
  output logic [2:0]           o_rx_state
);

  tx_state_t            r_tx_state;
  tx_state_t            w_tx_next;
  logic [3:0]           r_tx_cnt;
  logic [3:0]           w_tx_cnt_next;
  logic [c_FRAME_W-1:0] r_tx_buf;
  logic [31:0]          r_tx_csum;
  logic [31:0]          r_txdata;
  logic [3:0]           r_txk;
  logic                 r_tx_end;
  logic                 r_tx_busy;
  logic [31:0]          w_word;
  logic [3:0]           w_k;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 4'd0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= w_tx_cnt_next;
    end
  end

  // Next state plus the word that state puts on the wire. The word is
  // registered together with the state so every TX output is a flop.
  always_comb begin
    w_tx_next     = r_tx_state;
    w_tx_cnt_next = r_tx_cnt;
    case (r_tx_state)
      TX_IDLE: if (i_tx_start_flag) w_tx_next = TX_SOF;
      TX_SOF: begin
        w_tx_next     = TX_DATA;
        w_tx_cnt_next = 4'd0;
      end
      TX_DATA: begin
        if (r_tx_cnt == c_LAST_IDX) begin
          w_tx_next = TX_CSUM;
        end else begin
          w_tx_cnt_next = r_tx_cnt + 4'd1;
        end
      end
      TX_CSUM: w_tx_next = TX_EOF;
      TX_EOF:  w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase

    w_word = c_IDLE_WORD;
    w_k    = c_K_CTRL;
    case (w_tx_next)
      TX_SOF:  w_word = c_SOF_WORD;
      TX_DATA: begin
        w_word = r_tx_buf[c_FRAME_W-1 -: 32];
        w_k    = c_K_DATA;
      end
      TX_CSUM: begin
        w_word = r_tx_csum;
        w_k    = c_K_DATA;
      end
      TX_EOF:  w_word = c_EOF_WORD;
      default: w_word = c_IDLE_WORD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_buf  <= '0;
      r_tx_csum <= 32'd0;
      r_txdata  <= c_IDLE_WORD;
      r_txk     <= c_K_CTRL;
      r_tx_end  <= 1'b0;
      r_tx_busy <= 1'b0;
    end else begin
      r_txdata  <= w_word;
      r_txk     <= w_k;
      r_tx_end  <= (w_tx_next == TX_EOF);
      r_tx_busy <= (w_tx_next != TX_IDLE);
      if ((r_tx_state == TX_IDLE) && i_tx_start_flag) begin
        r_tx_buf  <= i_tx_data;
        r_tx_csum <= 32'd0;
      end else if (w_tx_next == TX_DATA) begin
        // Each data word leaves the top of the buffer and joins the sum.
        r_tx_buf  <= {r_tx_buf[c_FRAME_W-33:0], 32'd0};
        r_tx_csum <= r_tx_csum + r_tx_buf[c_FRAME_W-1 -: 32];
      end
    end
  end

  assign o_gt_txdata    = r_txdata;
  assign o_gt_txcharisk = r_txk;
  assign o_tx_end_flag  = r_tx_end;
  assign o_tx_busy      = r_tx_busy;
  assign o_tx_state     = r_tx_state;

  sfp_frame_rx u_rx (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rxdata      (i_gt_rxdata),
    .i_rxcharisk   (i_gt_rxcharisk),
    .i_rx_ready    (i_gt_rx_ready),
    .o_rx_data     (o_rx_data),
    .o_rx_end_flag (o_rx_end_flag),
    .o_rx_err_flag (o_rx_err_flag),
    .o_rx_err_cnt  (o_rx_err_cnt),
    .o_rx_state    (o_rx_state)
  );

endmodule
`default_nettype wire

// File: tb/tb_sfp_frame_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfp_frame_link
// Description : Self-checking bench for sfp_frame_link. Table of loopback
//               frames with hand-computed checksums, plus directed sequences
//               for resync, alignment loss, start handling, reset and
//               error-counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfp_frame_link;

  localparam logic [31:0] c_IDLE = 32'h0000_00BC;
  localparam logic [31:0] c_SOF  = 32'h0000_00FB;
  localparam logic [31:0] c_EOF  = 32'h0000_00FD;

  logic         clk;
  logic         rst;
  logic [383:0] tx_data;
  logic         tx_start;
  logic         tx_end;
  logic         tx_busy;
  logic [31:0]  gt_txdata;
  logic [3:0]   gt_txk;
  logic [31:0]  w_rxd;
  logic [3:0]   w_rxk;
  logic         rx_ready;
  logic [383:0] rx_data;
  logic         rx_end;
  logic         rx_err;
  logic [15:0]  rx_err_cnt;
  logic [2:0]   tx_state;
  logic [2:0]   rx_state;

  logic         r_lb;
  logic [31:0]  r_xor;
  logic [31:0]  r_inj_d;
  logic [3:0]   r_inj_k;

  assign w_rxd = r_lb ? (gt_txdata ^ r_xor) : r_inj_d;
  assign w_rxk = r_lb ? gt_txk : r_inj_k;

  sfp_frame_link dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_tx_data       (tx_data),
    .i_tx_start_flag (tx_start),
    .o_tx_end_flag   (tx_end),
    .o_tx_busy       (tx_busy),
    .o_gt_txdata     (gt_txdata),
    .o_gt_txcharisk  (gt_txk),
    .i_gt_rxdata     (w_rxd),
    .i_gt_rxcharisk  (w_rxk),
    .i_gt_rx_ready   (rx_ready),
    .o_rx_data       (rx_data),
    .o_rx_end_flag   (rx_end),
    .o_rx_err_flag   (rx_err),
    .o_rx_err_cnt    (rx_err_cnt),
    .o_tx_state      (tx_state),
    .o_rx_state      (rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [383:0] data;
    logic         corrupt;
    logic [31:0]  csum;
    logic         ok;
  } vec_t;

  vec_t         vecs [5];
  int           n_chk;
  int           n_pass;
  logic [383:0] exp_rx_data;
  logic [15:0]  exp_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] k);
    r_inj_d = w;
    r_inj_k = k;
    tick();
  endtask

  // Sends D1..D12, CSUM and EOF (the SOF is sent by the caller).
  task automatic send_body(input logic [383:0] d);
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < 12; i++) begin
      sum = sum + d[383-32*i -: 32];
      send_word(d[383-32*i -: 32], 4'b0000);
    end
    send_word(sum, 4'b0000);
    send_word(c_EOF, 4'b0001);
    r_inj_d = c_IDLE;
    r_inj_k = 4'b0001;
  endtask

  // Loopback frame: start at N, check every wire word N+1..N+15, then RX at N+16.
  task automatic run_frame(input int idx);
    logic [31:0] ew;
    logic [3:0]  ek;
    tx_data  = vecs[idx].data;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      r_xor = (vecs[idx].corrupt && k == 6) ? 32'h1 : 32'h0;
      if (k == 1) begin
        ew = c_SOF; ek = 4'b0001;
      end else if (k <= 13) begin
        ew = vecs[idx].data[383-32*(k-2) -: 32]; ek = 4'b0000;
      end else if (k == 14) begin
        ew = vecs[idx].csum; ek = 4'b0000;
      end else begin
        ew = c_EOF; ek = 4'b0001;
      end
      chk($sformatf("v%0d txdata N+%0d", idx, k), {352'd0, gt_txdata}, {352'd0, ew});
      chk($sformatf("v%0d txk N+%0d", idx, k), {380'd0, gt_txk}, {380'd0, ek});
      chk($sformatf("v%0d tx_end N+%0d", idx, k), {383'd0, tx_end}, {383'd0, (k == 15)});
      chk($sformatf("v%0d busy N+%0d", idx, k), {383'd0, tx_busy}, 384'd1);
      tick();
    end
    r_xor = 32'h0;
    if (vecs[idx].ok) exp_rx_data = vecs[idx].data;
    else exp_cnt = exp_cnt + 16'd1;
    chk($sformatf("v%0d rx_end", idx), {383'd0, rx_end}, {383'd0, vecs[idx].ok});
    chk($sformatf("v%0d rx_err", idx), {383'd0, rx_err}, {383'd0, !vecs[idx].ok});
    chk($sformatf("v%0d rx_data", idx), rx_data, exp_rx_data);
    chk($sformatf("v%0d err_cnt", idx), {368'd0, rx_err_cnt}, {368'd0, exp_cnt});
    chk($sformatf("v%0d busy after", idx), {383'd0, tx_busy}, 384'd0);
  endtask

  initial begin
    logic [383:0] inc;
    logic [383:0] fa;
    logic [383:0] fb;
    logic [383:0] fc;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    tx_data = '0;
    tx_start = 1'b0;
    rx_ready = 1'b1;
    r_lb = 1'b1;
    r_xor = 32'h0;
    r_inj_d = c_IDLE;
    r_inj_k = 4'b0001;
    exp_rx_data = '0;
    exp_cnt = 16'd0;

    inc = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
           32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
    vecs[0] = '{data: 384'd1,                    corrupt: 1'b0, csum: 32'h0000_0001, ok: 1'b1};
    vecs[1] = '{data: inc,                       corrupt: 1'b0, csum: 32'h0000_004E, ok: 1'b1};
    vecs[2] = '{data: inc,                       corrupt: 1'b1, csum: 32'h0000_004E, ok: 1'b0};
    vecs[3] = '{data: {12{32'hFFFF_FFFF}},       corrupt: 1'b0, csum: 32'hFFFF_FFF4, ok: 1'b1};
    vecs[4] = '{data: {12{32'hA5A5_A5A5}},       corrupt: 1'b0, csum: 32'hC3C3_C3BC, ok: 1'b1};

    tick();
    tick();
    chk("rst txdata", {352'd0, gt_txdata}, {352'd0, c_IDLE});
    chk("rst txk", {380'd0, gt_txk}, 384'd1);
    chk("rst tx_state", {381'd0, tx_state}, 384'd0);
    chk("rst rx_state", {381'd0, rx_state}, 384'd0);
    chk("rst rx_data", rx_data, 384'd0);
    chk("rst err_cnt", {368'd0, rx_err_cnt}, 384'd0);
    chk("rst flags", {381'd0, tx_end, rx_end, rx_err}, 384'd0);
    chk("rst busy", {383'd0, tx_busy}, 384'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_frame(i);

    // SOF in the D7 slot aborts and resyncs onto a following good frame.
    r_lb = 1'b0;
    fa = {12{32'h1357_9BDF}};
    fb = {32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60,
          32'h70, 32'h80, 32'h90, 32'hA0, 32'hB0, 32'hC0};
    send_word(c_SOF, 4'b0001);
    for (int i = 0; i < 6; i++) send_word(fa[383-32*i -: 32], 4'b0000);
    send_word(c_SOF, 4'b0001);
    exp_cnt = exp_cnt + 16'd1;
    chk("resync err flag", {383'd0, rx_err}, 384'd1);
    chk("resync rx_state", {381'd0, rx_state}, 384'd1);
    chk("resync err_cnt", {368'd0, rx_err_cnt}, {368'd0, exp_cnt});
    send_body(fb);
    exp_rx_data = fb;
    chk("resync end flag", {383'd0, rx_end}, 384'd1);
    chk("resync rx_data", rx_data, exp_rx_data);

    // Alignment loss mid-DATA drops the partial frame silently.
    send_word(c_SOF, 4'b0001);
    for (int i = 0; i < 4; i++) send_word(fa[383-32*i -: 32], 4'b0000);
    rx_ready = 1'b0;
    send_word(32'h1234_5678, 4'b0000);
    chk("rdy rx_state", {381'd0, rx_state}, 384'd0);
    chk("rdy flags", {382'd0, rx_end, rx_err}, 384'd0);
    rx_ready = 1'b1;
    send_word(32'h1234_5678, 4'b0000);
    send_word(c_IDLE, 4'b0001);
    chk("rdy still hunt", {381'd0, rx_state}, 384'd0);
    send_word(c_SOF, 4'b0001);
    send_body(fa);
    exp_rx_data = fa;
    chk("rdy end flag", {383'd0, rx_end}, 384'd1);
    chk("rdy rx_data", rx_data, exp_rx_data);
    chk("rdy err_cnt", {368'd0, rx_err_cnt}, {368'd0, exp_cnt});

    // Starts while busy and in the EOF cycle are ignored; the next IDLE one is taken.
    r_lb = 1'b1;
    fc = ~fb;
    tx_data = fa;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    chk("busy SOF", {352'd0, gt_txdata}, {352'd0, c_SOF});
    tick();
    tick();
    tx_data = fb;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    chk("busy start ignored D3", {352'd0, gt_txdata}, {352'd0, fa[319:288]});
    chk("busy start state", {381'd0, tx_state}, 384'd2);
    for (int k = 5; k <= 15; k++) tick();
    chk("eof word", {352'd0, gt_txdata}, {352'd0, c_EOF});
    chk("eof state", {381'd0, tx_state}, 384'd4);
    tx_data = fb;
    tx_start = 1'b1;
    tick();
    exp_rx_data = fa;
    chk("eof start ignored state", {381'd0, tx_state}, 384'd0);
    chk("eof start ignored word", {352'd0, gt_txdata}, {352'd0, c_IDLE});
    chk("eof start ignored busy", {383'd0, tx_busy}, 384'd0);
    chk("frame A rx_end", {383'd0, rx_end}, 384'd1);
    chk("frame A rx_data", rx_data, exp_rx_data);
    tx_data = fc;
    tick();
    tx_start = 1'b0;
    chk("next start SOF", {352'd0, gt_txdata}, {352'd0, c_SOF});
    chk("next start busy", {383'd0, tx_busy}, 384'd1);
    for (int k = 2; k <= 16; k++) tick();
    exp_rx_data = fc;
    chk("frame C rx_end", {383'd0, rx_end}, 384'd1);
    chk("frame C rx_data", rx_data, exp_rx_data);

    // Reset mid-frame truncates TX at once and clears RX results.
    tx_data = fa;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    exp_rx_data = '0;
    exp_cnt = 16'd0;
    chk("midrst txdata", {352'd0, gt_txdata}, {352'd0, c_IDLE});
    chk("midrst txk", {380'd0, gt_txk}, 384'd1);
    chk("midrst states", {378'd0, tx_state, rx_state}, 384'd0);
    chk("midrst busy", {383'd0, tx_busy}, 384'd0);
    chk("midrst rx_data", rx_data, exp_rx_data);
    rst = 1'b0;
    tick();

    // A continuous SOF stream makes every word after the first an abort.
    r_lb = 1'b0;
    r_inj_d = c_SOF;
    r_inj_k = 4'b0001;
    for (int i = 0; i < 100; i++) tick();
    chk("sat count 99", {368'd0, rx_err_cnt}, 384'd99);
    for (int i = 100; i < 65536; i++) tick();
    chk("sat reach FFFF", {368'd0, rx_err_cnt}, {368'd0, 16'hFFFF});
    for (int i = 0; i < 4; i++) tick();
    chk("sat hold FFFF", {368'd0, rx_err_cnt}, {368'd0, 16'hFFFF});
    chk("sat err flag", {383'd0, rx_err}, 384'd1);
    r_inj_d = c_IDLE;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
